bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-port arbiter sharing one single-port, 1-cycle-read-latency BRAM between the CPU memory path (port A) and a second bus master such as the OAM/HDMA DMA engine (port B). It sits between the memory router's per-region select and the BRAM primitive. It serialises requests with a REQ/GNT/ACK handshake, masks addresses to the BRAM-local range, and returns registered read data to the winner.

## Interface
- P_OFFSET_MASK, 16'h00FF, AND-mask applied to the latched address to form the BRAM-local address.
- P_FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins ties.
- I_CLK  in  1  system clock, all logic on rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_A_REQ / I_B_REQ  in  1  access request; held with its attributes until GNT is seen.
- I_A_WE / I_B_WE  in  1  1 = write, 0 = read.
- I_A_ADDR / I_B_ADDR  in  16  byte address.
- I_A_WDATA / I_B_WDATA  in  8  write data.
- I_B_LOCK  in  1  while high, port A is never granted (DMA burst ownership).
- O_A_GNT / O_B_GNT  out  1  one-cycle pulse: request accepted, attributes latched.
- O_A_ACK / O_B_ACK  out  1  one-cycle pulse: access complete; for reads, RDATA valid this cycle.
- O_A_RDATA / O_B_RDATA  out  8  registered read data, held until that port's next read ACK.
- O_BRAM_EN  out  1  BRAM enable.
- O_BRAM_WE  out  1  BRAM write enable.
- O_BRAM_ADDR  out  16  latched address & P_OFFSET_MASK.
- O_BRAM_DIN  out  8  latched write data.
- I_BRAM_DOUT  in  8  BRAM read data, valid the cycle after an enabled read edge.

## Operation
- All outputs are registered. Reset values: every GNT/ACK/EN/WE is 0. O_BRAM_ADDR, O_BRAM_DIN and both RDATA are 0. State is IDLE. The round-robin pointer favours A.
- States:
  - IDLE: if any eligible request, select winner, latch its ADDR/WE/WDATA into BRAM regs, pulse winner GNT, go to ISSUE; else stay.
  - ISSUE: O_BRAM_EN=1 (O_BRAM_WE = latched WE) for exactly this cycle; go to CAPTURE.
  - CAPTURE: EN/WE=0. For a read, load I_BRAM_DOUT into the owner's RDATA. Pulse the owner's ACK (read or write). If any eligible request, arbitrate and grant exactly as in IDLE and go to ISSUE; else go to IDLE.
- Eligibility: B is eligible when I_B_REQ is high. A is eligible when I_A_REQ is high and I_B_LOCK is low.
- Selection when both are eligible:
  - P_FIXED_PRIO=1: A wins.
  - P_FIXED_PRIO=0: the pointer's favourite wins, then the pointer moves to the loser.
  - A single eligible requester always wins and does not move the pointer.
- A requester must drop REQ or present a new access in the cycle after its GNT. The arbiter does not sample REQ in ISSUE.
- Reset in any state aborts the access in flight. No ACK is issued for it, RDATA is cleared, and EN drops in the next cycle.
- A write never modifies either RDATA. The non-owner's RDATA is never modified.

## Timing
- Request sampled at edge E0 (IDLE or CAPTURE) → GNT and EN high in cycle E0..E1 → BRAM access at E1 → DOUT captured at E2 → ACK high in cycle E2..E3.
- Latency from the sampled REQ to ACK is 2 cycles.
- Peak throughput is one access per 2 cycles. Back-to-back grants are possible, with the new GNT coinciding with the previous ACK.
- GNT and ACK of the same port can be high in the same cycle only for back-to-back accesses by that port.
- I_B_LOCK is sampled at each arbitration edge. Raising it mid-access does not cancel an A access already granted.

## Test plan
- Reset, A reads 0x8012 with BRAM[0x12]=0x5A → GNT one cycle after REQ, O_BRAM_ADDR=0x0012 with EN=1 one cycle, O_A_ACK 2 cycles after GNT edge with O_A_RDATA=0x5A.
- B writes 0xC3 to 0x0007, then B reads 0x0007 → EN/WE=1 one cycle with DIN=0xC3, ACK; read returns 0xC3; O_A_RDATA unchanged.
- A and B both hold REQ continuously, P_FIXED_PRIO=0 → grants alternate A,B,A,B, one grant every 2 cycles, each GNT coincident with the previous ACK.
- Same stimulus with P_FIXED_PRIO=1 → only A granted; B granted in the first arbitration after A drops REQ.
- I_B_LOCK=1 with A requesting and B issuing 4 reads → 4 B grants, zero A grants; A is granted at the first arbitration edge after LOCK falls.
- I_RESET asserted during ISSUE of an A read → no ACK, O_A_RDATA=0x00, EN=0 next cycle, state IDLE; next request completes normally.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-master arbiter in front of a single-port BRAM with 1-cycle read latency.
// Serialises A/B accesses via REQ/GNT/ACK and returns registered read data.
module bram_arbiter #(
   parameter logic [15:0] P_OFFSET_MASK = 16'h00FF,
   parameter bit          P_FIXED_PRIO  = 1'b0
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_A_REQ,
   input  logic        I_A_WE,
   input  logic [15:0] I_A_ADDR,
   input  logic [7:0]  I_A_WDATA,
   input  logic        I_B_REQ,
   input  logic        I_B_WE,
   input  logic [15:0] I_B_ADDR,
   input  logic [7:0]  I_B_WDATA,
   input  logic        I_B_LOCK,
   output logic        O_A_GNT,
   output logic        O_B_GNT,
   output logic        O_A_ACK,
   output logic        O_B_ACK,
   output logic [7:0]  O_A_RDATA,
   output logic [7:0]  O_B_RDATA,
   output logic        O_BRAM_EN,
   output logic        O_BRAM_WE,
   output logic [15:0] O_BRAM_ADDR,
   output logic [7:0]  O_BRAM_DIN,
   input  logic [7:0]  I_BRAM_DOUT
);

   // state      | meaning
   // ST_IDLE    | no access in flight, arbitrate on each edge
   // ST_ISSUE   | BRAM enabled for the granted access
   // ST_CAPTURE | read data on I_BRAM_DOUT; ack owner and re-arbitrate
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_t;

   state_t      state_q, state_d;
   logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
   logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic        en_q, en_d, we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  din_q, din_d;
   logic [7:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic        owner_b_q, owner_b_d;
   logic        lat_we_q, lat_we_d;
   logic        ptr_b_q, ptr_b_d;
   logic        a_elig, b_elig, pick_b;

   assign a_elig = I_A_REQ & ~I_B_LOCK;
   assign b_elig = I_B_REQ;
   // ptr_b_q set means B is favoured on a tie
   assign pick_b = b_elig & (~a_elig | (~P_FIXED_PRIO & ptr_b_q));

   always_comb begin
      state_d   = state_q;
      a_gnt_d   = 1'b0;
      b_gnt_d   = 1'b0;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      en_d      = 1'b0;
      we_d      = 1'b0;
      addr_d    = addr_q;
      din_d     = din_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      owner_b_d = owner_b_q;
      lat_we_d  = lat_we_q;
      ptr_b_d   = ptr_b_q;

      case (state_q)
         ST_ISSUE: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            state_d = ST_IDLE;
            if (owner_b_q) begin
               b_ack_d = 1'b1;
               if (!lat_we_q) b_rdata_d = I_BRAM_DOUT;
            end else begin
               a_ack_d = 1'b1;
               if (!lat_we_q) a_rdata_d = I_BRAM_DOUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_q != ST_ISSUE) && (a_elig || b_elig)) begin
         state_d   = ST_ISSUE;
         en_d      = 1'b1;
         owner_b_d = pick_b;
         if (pick_b) begin
            b_gnt_d = 1'b1;
            we_d    = I_B_WE;
            addr_d  = I_B_ADDR & P_OFFSET_MASK;
            din_d   = I_B_WDATA;
         end else begin
            a_gnt_d = 1'b1;
            we_d    = I_A_WE;
            addr_d  = I_A_ADDR & P_OFFSET_MASK;
            din_d   = I_A_WDATA;
         end
         lat_we_d = we_d;
         if (a_elig && b_elig && !P_FIXED_PRIO) ptr_b_d = ~pick_b;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q   <= ST_IDLE;
         a_gnt_q   <= 1'b0;
         b_gnt_q   <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         en_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         owner_b_q <= 1'b0;
         lat_we_q  <= 1'b0;
         ptr_b_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_gnt_q   <= a_gnt_d;
         b_gnt_q   <= b_gnt_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         en_q      <= en_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         owner_b_q <= owner_b_d;
         lat_we_q  <= lat_we_d;
         ptr_b_q   <= ptr_b_d;
      end
   end

   assign O_A_GNT     = a_gnt_q;
   assign O_B_GNT     = b_gnt_q;
   assign O_A_ACK     = a_ack_q;
   assign O_B_ACK     = b_ack_q;
   assign O_A_RDATA   = a_rdata_q;
   assign O_B_RDATA   = b_rdata_q;
   assign O_BRAM_EN   = en_q;
   assign O_BRAM_WE   = we_q;
   assign O_BRAM_ADDR = addr_q;
   assign O_BRAM_DIN  = din_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: round-robin instance plus a fixed-priority
// instance sharing stimulus, each with its own behavioural BRAM.
module tb_bram_arbiter;

   logic        I_CLK = 1'b0;
   logic        I_RESET;
   logic        I_A_REQ, I_A_WE, I_B_REQ, I_B_WE, I_B_LOCK;
   logic [15:0] I_A_ADDR, I_B_ADDR;
   logic [7:0]  I_A_WDATA, I_B_WDATA;

   logic        a_gnt, b_gnt, a_ack, b_ack, bram_en, bram_we;
   logic [7:0]  a_rdata, b_rdata, bram_din, bram_dout;
   logic [15:0] bram_addr;

   logic        fp_a_gnt, fp_b_gnt, fp_a_ack, fp_b_ack, fp_en, fp_we;
   logic [7:0]  fp_a_rdata, fp_b_rdata, fp_din, fp_dout;
   logic [15:0] fp_addr;

   logic        pl_en;
   logic [7:0]  pl_addr, pl_data;
   logic [7:0]  mem0 [0:255];
   logic [7:0]  mem1 [0:255];

   int n_cmp = 0;
   int n_err = 0;

   always #5 I_CLK = ~I_CLK;

   bram_arbiter #(.P_OFFSET_MASK(16'h00FF), .P_FIXED_PRIO(1'b0)) dut (
      .I_CLK(I_CLK), .I_RESET(I_RESET),
      .I_A_REQ(I_A_REQ), .I_A_WE(I_A_WE), .I_A_ADDR(I_A_ADDR), .I_A_WDATA(I_A_WDATA),
      .I_B_REQ(I_B_REQ), .I_B_WE(I_B_WE), .I_B_ADDR(I_B_ADDR), .I_B_WDATA(I_B_WDATA),
      .I_B_LOCK(I_B_LOCK),
      .O_A_GNT(a_gnt), .O_B_GNT(b_gnt), .O_A_ACK(a_ack), .O_B_ACK(b_ack),
      .O_A_RDATA(a_rdata), .O_B_RDATA(b_rdata),
      .O_BRAM_EN(bram_en), .O_BRAM_WE(bram_we), .O_BRAM_ADDR(bram_addr),
      .O_BRAM_DIN(bram_din), .I_BRAM_DOUT(bram_dout)
   );

   bram_arbiter #(.P_OFFSET_MASK(16'h00FF), .P_FIXED_PRIO(1'b1)) dut_fp (
      .I_CLK(I_CLK), .I_RESET(I_RESET),
      .I_A_REQ(I_A_REQ), .I_A_WE(I_A_WE), .I_A_ADDR(I_A_ADDR), .I_A_WDATA(I_A_WDATA),
      .I_B_REQ(I_B_REQ), .I_B_WE(I_B_WE), .I_B_ADDR(I_B_ADDR), .I_B_WDATA(I_B_WDATA),
      .I_B_LOCK(I_B_LOCK),
      .O_A_GNT(fp_a_gnt), .O_B_GNT(fp_b_gnt), .O_A_ACK(fp_a_ack), .O_B_ACK(fp_b_ack),
      .O_A_RDATA(fp_a_rdata), .O_B_RDATA(fp_b_rdata),
      .O_BRAM_EN(fp_en), .O_BRAM_WE(fp_we), .O_BRAM_ADDR(fp_addr),
      .O_BRAM_DIN(fp_din), .I_BRAM_DOUT(fp_dout)
   );

   always @(posedge I_CLK) begin
      if (pl_en) begin
         mem0[pl_addr] <= pl_data;
         mem1[pl_addr] <= pl_data;
      end else begin
         if (bram_en) begin
            if (bram_we) mem0[bram_addr[7:0]] <= bram_din;
            bram_dout <= mem0[bram_addr[7:0]];
         end
         if (fp_en) begin
            if (fp_we) mem1[fp_addr[7:0]] <= fp_din;
            fp_dout <= mem1[fp_addr[7:0]];
         end
      end
   end

   task automatic step();
      @(posedge I_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      step();
      pl_en = 1'b0;
   endtask

   initial begin
      I_RESET = 1'b1; I_B_LOCK = 1'b0;
      I_A_REQ = 1'b0; I_A_WE = 1'b0; I_A_ADDR = '0; I_A_WDATA = '0;
      I_B_REQ = 1'b0; I_B_WE = 1'b0; I_B_ADDR = '0; I_B_WDATA = '0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      step(); step();
      preload(8'h12, 8'h5A);
      preload(8'h30, 8'h99);
      step();

      chk("rst_a_gnt", {15'd0, a_gnt}, 16'd0);
      chk("rst_b_gnt", {15'd0, b_gnt}, 16'd0);
      chk("rst_acks", {14'd0, a_ack, b_ack}, 16'd0);
      chk("rst_en_we", {14'd0, bram_en, bram_we}, 16'd0);
      chk("rst_addr", bram_addr, 16'h0000);
      chk("rst_din", {8'd0, bram_din}, 16'h0000);
      chk("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
      I_RESET = 1'b0;
      step();

      // A reads 0x8012
      I_A_REQ = 1'b1; I_A_ADDR = 16'h8012; I_A_WE = 1'b0;
      step();
      chk("t1_a_gnt", {15'd0, a_gnt}, 16'd1);
      chk("t1_en", {15'd0, bram_en}, 16'd1);
      chk("t1_we", {15'd0, bram_we}, 16'd0);
      chk("t1_addr", bram_addr, 16'h0012);
      chk("t1_ack_early", {15'd0, a_ack}, 16'd0);
      I_A_REQ = 1'b0;
      step();
      chk("t1_en_drop", {14'd0, bram_en, a_gnt}, 16'd0);
      chk("t1_ack_early2", {15'd0, a_ack}, 16'd0);
      step();
      chk("t1_a_ack", {15'd0, a_ack}, 16'd1);
      chk("t1_a_rdata", {8'd0, a_rdata}, 16'h005A);
      chk("t1_b_ack", {15'd0, b_ack}, 16'd0);
      step();
      chk("t1_ack_pulse", {15'd0, a_ack}, 16'd0);
      chk("t1_rdata_hold", {8'd0, a_rdata}, 16'h005A);

      // B writes 0xC3 to 0x0007, then reads it back
      I_B_REQ = 1'b1; I_B_WE = 1'b1; I_B_ADDR = 16'h0007; I_B_WDATA = 8'hC3;
      step();
      chk("t2_b_gnt", {15'd0, b_gnt}, 16'd1);
      chk("t2_en_we", {14'd0, bram_en, bram_we}, 16'd3);
      chk("t2_din", {8'd0, bram_din}, 16'h00C3);
      chk("t2_addr", bram_addr, 16'h0007);
      I_B_REQ = 1'b0;
      step();
      chk("t2_en_drop", {14'd0, bram_en, bram_we}, 16'd0);
      step();
      chk("t2_wr_ack", {15'd0, b_ack}, 16'd1);
      chk("t2_wr_rdata", {a_rdata, b_rdata}, 16'h5A00);
      I_B_REQ = 1'b1; I_B_WE = 1'b0;
      step();
      chk("t2_rd_gnt", {15'd0, b_gnt}, 16'd1);
      I_B_REQ = 1'b0;
      step();
      step();
      chk("t2_rd_ack", {15'd0, b_ack}, 16'd1);
      chk("t2_rd_rdata", {a_rdata, b_rdata}, 16'h5AC3);
      chk("t2_fp_rd_rdata", {fp_a_rdata, fp_b_rdata}, 16'h5AC3);

      // Both request continuously
      I_A_REQ = 1'b1; I_A_WE = 1'b0; I_A_ADDR = 16'h0012;
      I_B_REQ = 1'b1; I_B_WE = 1'b0; I_B_ADDR = 16'h0007;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("t3_rr_gnt%0d", k), {14'd0, a_gnt, b_gnt}, (k % 2 == 0) ? 16'd2 : 16'd1);
         chk($sformatf("t3_fp_gnt%0d", k), {14'd0, fp_a_gnt, fp_b_gnt}, 16'd2);
         if (k > 0) begin
            chk($sformatf("t3_rr_ack%0d", k), {14'd0, a_ack, b_ack}, (k % 2 == 1) ? 16'd2 : 16'd1);
            chk($sformatf("t3_fp_ack%0d", k), {14'd0, fp_a_ack, fp_b_ack}, 16'd2);
         end
         step();
         chk($sformatf("t3_gap%0d", k), {12'd0, a_gnt, b_gnt, fp_a_gnt, fp_b_gnt}, 16'd0);
      end
      I_A_REQ = 1'b0;
      step();
      chk("t3_rr_tail", {12'd0, a_gnt, b_gnt, a_ack, b_ack}, 16'b0101);
      chk("t3_fp_tail", {12'd0, fp_a_gnt, fp_b_gnt, fp_a_ack, fp_b_ack}, 16'b0110);
      chk("t3_fp_a_rdata", {8'd0, fp_a_rdata}, 16'h005A);
      I_B_REQ = 1'b0;
      step();
      step();
      chk("t3_last_ack", {14'd0, b_ack, fp_b_ack}, 16'd3);
      chk("t3_b_rdata", {b_rdata, fp_b_rdata}, 16'hC3C3);

      // LOCK holds A off while B does 4 reads
      I_B_LOCK = 1'b1;
      I_A_REQ = 1'b1; I_A_ADDR = 16'h0012;
      I_B_REQ = 1'b1; I_B_ADDR = 16'h0007;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("t4_gnt%0d", k), {14'd0, a_gnt, b_gnt}, 16'd1);
         if (k > 0) chk($sformatf("t4_ack%0d", k), {15'd0, b_ack}, 16'd1);
         if (k == 3) begin
            I_B_REQ = 1'b0; I_B_LOCK = 1'b0;
         end
         step();
         chk($sformatf("t4_gap%0d", k), {14'd0, a_gnt, b_gnt}, 16'd0);
      end
      step();
      chk("t4_a_after_lock", {12'd0, a_gnt, b_gnt, a_ack, b_ack}, 16'b1001);
      I_A_REQ = 1'b0;
      step();
      step();
      chk("t4_a_ack", {15'd0, a_ack}, 16'd1);
      chk("t4_a_rdata", {8'd0, a_rdata}, 16'h005A);

      // Reset during ISSUE of an A read
      I_A_REQ = 1'b1; I_A_ADDR = 16'h0130;
      step();
      chk("t5_gnt", {14'd0, a_gnt, bram_en}, 16'd3);
      chk("t5_addr", bram_addr, 16'h0030);
      I_A_REQ = 1'b0; I_RESET = 1'b1;
      step();
      chk("t5_rst_en", {13'd0, bram_en, a_gnt, a_ack}, 16'd0);
      chk("t5_rst_rdata", {8'd0, a_rdata}, 16'h0000);
      I_RESET = 1'b0;
      step();
      chk("t5_no_ack", {14'd0, a_ack, bram_en}, 16'd0);
      step();
      chk("t5_idle", {14'd0, a_ack, a_gnt}, 16'd0);
      I_A_REQ = 1'b1;
      step();
      chk("t5_regnt", {15'd0, a_gnt}, 16'd1);
      I_A_REQ = 1'b0;
      step();
      step();
      chk("t5_reack", {15'd0, a_ack}, 16'd1);
      chk("t5_rerdata", {8'd0, a_rdata}, 16'h0099);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
